// File: rtl/fpga_slave_pkg.sv
// Shared definitions for the UART frame parser.
//   FRAME_LEN      : bytes per frame (16)
//   SYNC_FF/SYNC_00: the two sync byte values
//   parser_state_t : HUNT (indices 0-3) / PAYLOAD (indices 4-15)
//   byte_kind_t    : how a byte at a given index is checked
//   fixed_byte()   : expected value of every fixed byte, by index
//   byte_kind()    : classification of every index
package fpga_slave_pkg;

  localparam int unsigned FRAME_LEN = 16;

  localparam logic [7:0] SYNC_FF = 8'hFF;
  localparam logic [7:0] SYNC_00 = 8'h00;

  localparam logic [3:0] HUNT_LAST_IDX  = 4'd3;
  localparam logic [3:0] FRAME_LAST_IDX = 4'(FRAME_LEN - 1);

  typedef enum logic {
    HUNT    = 1'b0,
    PAYLOAD = 1'b1
  } parser_state_t;

  typedef enum logic [1:0] {
    KIND_FIXED    = 2'd0,  // must equal fixed_byte(idx)
    KIND_HI_NIBBLE = 2'd1, // channel bits [11:8], upper nibble must be 0
    KIND_LOW      = 2'd2   // channel bits [7:0], any value
  } byte_kind_t;

  // Frame: FF 00 00 FF hi1 lo1 FF 00 00 00 00 FF hi2 lo2 FF 00
  function automatic logic [7:0] fixed_byte(input logic [3:0] idx);
    logic [7:0] val;
    val = SYNC_00;
    case (idx)
      4'd0, 4'd3, 4'd6, 4'd11, 4'd14: val = SYNC_FF;
      default:                        val = SYNC_00;
    endcase
    return val;
  endfunction

  function automatic byte_kind_t byte_kind(input logic [3:0] idx);
    byte_kind_t kind;
    kind = KIND_FIXED;
    case (idx)
      4'd4, 4'd12: kind = KIND_HI_NIBBLE;
      4'd5, 4'd13: kind = KIND_LOW;
      default:     kind = KIND_FIXED;
    endcase
    return kind;
  endfunction

endpackage

// File: rtl/uart_byte_timer.sv
// Inter-byte gap timer for the frame parser.
//   clk, rst : clock and synchronous active-high reset
//   clear    : restart the gap count (a byte was accepted)
//   enable   : a frame is in progress, count idle cycles
//   expired  : more than LIMIT idle cycles have elapsed
// Only instantiated when FRAME_PARSER_TIMEOUT_EN is defined.
module uart_byte_timer #(
  parameter int unsigned LIMIT = 20000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = $clog2(LIMIT + 2);

  logic [CW-1:0] count;

  // Saturates at LIMIT+1 so expired stays asserted until cleared.
  always_ff @(posedge clk) begin
    if (rst || clear || !enable) begin
      count <= '0;
    end else if (count <= CW'(LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = enable && !clear && (count > CW'(LIMIT));

endmodule

// File: rtl/uart_frame_parser.sv
// Parses 16-byte sensor frames from a UART byte stream.
//   sys_clk, sys_rst   : clock, synchronous active-high reset
//   rx_data            : received byte
//   rx_data_valid      : rx_data is valid
//   rx_data_ready      : parser accepts a byte (high whenever out of reset)
//   ch1_data, ch2_data : last good 12-bit channel samples
//   frame_valid        : one-cycle pulse after a good frame completes
//   frame_err          : one-cycle pulse after an in-progress frame aborts
//   err_cnt            : saturating count of aborted frames
// Optional: define FRAME_PARSER_TIMEOUT_EN to abort frames whose
// inter-byte gap exceeds CLK_FRE*TIMEOUT_US cycles.
module uart_frame_parser
  import fpga_slave_pkg::*;
#(
  parameter int unsigned CLK_FRE    = 100,
  parameter int unsigned TIMEOUT_US = 200
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_data_valid,
  output logic        rx_data_ready,
  output logic [11:0] ch1_data,
  output logic [11:0] ch2_data,
  output logic        frame_valid,
  output logic        frame_err,
  output logic [15:0] err_cnt
);

  parser_state_t state, state_next;
  logic [3:0]    idx, idx_next;
  logic [11:0]   ch1_stage, ch1_stage_next;
  logic [11:0]   ch2_stage, ch2_stage_next;
  logic          accept;
  logic          byte_ok;
  logic          complete;
  logic          abort;

  assign rx_data_ready = ~sys_rst;
  assign accept        = rx_data_valid & rx_data_ready;

`ifdef FRAME_PARSER_TIMEOUT_EN
  logic timer_expired;
  logic timer_enable;

  assign timer_enable = (state == PAYLOAD) || (idx != '0);

  uart_byte_timer #(
    .LIMIT(CLK_FRE * TIMEOUT_US)
  ) u_timer (
    .clk    (sys_clk),
    .rst    (sys_rst),
    .clear  (accept),
    .enable (timer_enable),
    .expired(timer_expired)
  );
`endif

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state       <= HUNT;
      idx         <= '0;
      ch1_stage   <= '0;
      ch2_stage   <= '0;
      ch1_data    <= '0;
      ch2_data    <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      err_cnt     <= '0;
    end else begin
      state       <= state_next;
      idx         <= idx_next;
      ch1_stage   <= ch1_stage_next;
      ch2_stage   <= ch2_stage_next;
      frame_valid <= complete;
      frame_err   <= abort;
      if (complete) begin
        ch1_data <= ch1_stage;
        ch2_data <= ch2_stage;
      end
      if (abort && (err_cnt != '1)) begin
        err_cnt <= err_cnt + 16'd1;
      end
    end
  end

  always_comb begin
    state_next     = state;
    idx_next       = idx;
    ch1_stage_next = ch1_stage;
    ch2_stage_next = ch2_stage;
    byte_ok        = 1'b0;
    complete       = 1'b0;
    abort          = 1'b0;

    if (accept) begin
      if (state == HUNT) begin
        if (rx_data == fixed_byte(idx)) begin
          idx_next = idx + 4'd1;
          if (idx == HUNT_LAST_IDX) begin
            state_next = PAYLOAD;
          end
        end else begin
          // A stray FF may itself be the start of the next sync pattern.
          idx_next = (rx_data == SYNC_FF) ? 4'd1 : 4'd0;
        end
      end else begin
        unique case (byte_kind(idx))
          KIND_HI_NIBBLE: byte_ok = (rx_data[7:4] == 4'h0);
          KIND_LOW:       byte_ok = 1'b1;
          default:        byte_ok = (rx_data == fixed_byte(idx));
        endcase

        case (idx)
          4'd4:    ch1_stage_next[11:8] = rx_data[3:0];
          4'd5:    ch1_stage_next[7:0]  = rx_data;
          4'd12:   ch2_stage_next[11:8] = rx_data[3:0];
          4'd13:   ch2_stage_next[7:0]  = rx_data;
          default: ;
        endcase

        if (!byte_ok) begin
          // The offending byte is re-evaluated as frame index 0.
          abort      = 1'b1;
          state_next = HUNT;
          idx_next   = (rx_data == SYNC_FF) ? 4'd1 : 4'd0;
        end else if (idx == FRAME_LAST_IDX) begin
          complete   = 1'b1;
          state_next = HUNT;
          idx_next   = '0;
        end else begin
          idx_next = idx + 4'd1;
        end
      end
    end
`ifdef FRAME_PARSER_TIMEOUT_EN
    else if (timer_expired) begin
      // A stalled sync match is dropped silently; only a stalled payload counts.
      abort      = (state == PAYLOAD);
      state_next = HUNT;
      idx_next   = '0;
    end
`endif
  end

endmodule

// File: tb/tb_uart_frame_parser.sv
module tb_uart_frame_parser;

  logic        sys_clk;
  logic        sys_rst;
  logic [7:0]  rx_data;
  logic        rx_data_valid;
  logic        rx_data_ready;
  logic [11:0] ch1_data;
  logic [11:0] ch2_data;
  logic        frame_valid;
  logic        frame_err;
  logic [15:0] err_cnt;

  int checks = 0;
  int errors = 0;

  int valid_seen = 0;
  int err_seen   = 0;
  int both_seen  = 0;
  int valid_base;
  int err_base;

  uart_frame_parser #(
    .CLK_FRE   (100),
    .TIMEOUT_US(2)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .rx_data      (rx_data),
    .rx_data_valid(rx_data_valid),
    .rx_data_ready(rx_data_ready),
    .ch1_data     (ch1_data),
    .ch2_data     (ch2_data),
    .frame_valid  (frame_valid),
    .frame_err    (frame_err),
    .err_cnt      (err_cnt)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  always @(negedge sys_clk) begin
    if (frame_valid === 1'b1) valid_seen++;
    if (frame_err === 1'b1) err_seen++;
    if (frame_valid === 1'b1 && frame_err === 1'b1) both_seen++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] frame_byte(input int unsigned i, input logic [11:0] c1,
                                            input logic [11:0] c2);
    logic [7:0] b;
    case (i)
      0, 3, 6, 11, 14: b = 8'hFF;
      4:               b = {4'h0, c1[11:8]};
      5:               b = c1[7:0];
      12:              b = {4'h0, c2[11:8]};
      13:              b = c2[7:0];
      default:         b = 8'h00;
    endcase
    return b;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    rx_data       = b;
    rx_data_valid = 1'b1;
    @(posedge sys_clk);
    #1;
    rx_data_valid = 1'b0;
    rx_data       = '0;
  endtask

  // Sends bytes first..last of a frame; byte mod_idx (if >=0) replaced by mod_val.
  task automatic send_frame(input logic [11:0] c1, input logic [11:0] c2,
                            input int unsigned first, input int unsigned last,
                            input int mod_idx, input logic [7:0] mod_val);
    for (int unsigned i = first; i <= last; i++) begin
      if (int'(i) == mod_idx) send_byte(mod_val);
      else send_byte(frame_byte(i, c1, c2));
    end
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    idle(2);
    sys_rst = 1'b0;
    valid_base = valid_seen;
    err_base   = err_seen;
  endtask

  initial begin
    sys_rst       = 1'b1;
    rx_data       = '0;
    rx_data_valid = 1'b0;
    idle(3);

    // Reset state
    check("rst_ready", 32'(rx_data_ready), 32'h0);
    check("rst_ch1", 32'(ch1_data), 32'h0);
    check("rst_ch2", 32'(ch2_data), 32'h0);
    check("rst_valid", 32'(frame_valid), 32'h0);
    check("rst_err", 32'(frame_err), 32'h0);
    check("rst_errcnt", 32'(err_cnt), 32'h0);
    sys_rst = 1'b0;
    #1;
    check("ready_out_of_reset", 32'(rx_data_ready), 32'h1);
    valid_base = valid_seen;
    err_base   = err_seen;

    // Good frame 5A3/0F1; outputs must not move before completion
    send_frame(12'h5A3, 12'h0F1, 0, 13, -1, 8'h00);
    check("A_ch1_staged_hidden", 32'(ch1_data), 32'h0);
    check("A_ch2_staged_hidden", 32'(ch2_data), 32'h0);
    send_frame(12'h5A3, 12'h0F1, 14, 15, -1, 8'h00);
    check("A_valid_now", 32'(frame_valid), 32'h1);
    idle(3);
    check("A_valid_count", 32'(valid_seen - valid_base), 32'd1);
    check("A_err_count", 32'(err_seen - err_base), 32'd0);
    check("A_ch1", 32'(ch1_data), 32'h5A3);
    check("A_ch2", 32'(ch2_data), 32'h0F1);
    check("A_errcnt", 32'(err_cnt), 32'h0);

    // Garbage then resync: 12 34 FF, then frame 001/FFF
    do_reset();
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'hFF);
    send_frame(12'h001, 12'hFFF, 0, 15, -1, 8'h00);
    idle(3);
    check("B_valid_count", 32'(valid_seen - valid_base), 32'd1);
    check("B_err_count", 32'(err_seen - err_base), 32'd0);
    check("B_ch1", 32'(ch1_data), 32'h001);
    check("B_ch2", 32'(ch2_data), 32'hFFF);
    check("B_errcnt", 32'(err_cnt), 32'h0);

    // Good frame, then a frame whose byte 4 has a non-zero upper nibble
    do_reset();
    send_frame(12'h5A3, 12'h0F1, 0, 15, -1, 8'h00);
    idle(2);
    valid_base = valid_seen;
    send_frame(12'h5A3, 12'h0F1, 0, 15, 4, 8'h15);
    idle(3);
    check("C_err_count", 32'(err_seen - err_base), 32'd1);
    check("C_valid_after_bad", 32'(valid_seen - valid_base), 32'd0);
    check("C_errcnt", 32'(err_cnt), 32'h1);
    check("C_ch1_held", 32'(ch1_data), 32'h5A3);
    check("C_ch2_held", 32'(ch2_data), 32'h0F1);

    // Frame with byte 9 = 01 immediately followed by good frame 7FF/800
    do_reset();
    send_frame(12'h111, 12'h0F1, 0, 15, 9, 8'h01);
    send_frame(12'h7FF, 12'h800, 0, 15, -1, 8'h00);
    idle(3);
    check("D_err_count", 32'(err_seen - err_base), 32'd1);
    check("D_errcnt", 32'(err_cnt), 32'h1);
    check("D_valid_count", 32'(valid_seen - valid_base), 32'd1);
    check("D_ch1", 32'(ch1_data), 32'h7FF);
    check("D_ch2", 32'(ch2_data), 32'h800);

    // Six bytes then a 250-cycle gap
    do_reset();
    send_frame(12'h123, 12'h456, 0, 5, -1, 8'h00);
    idle(250);
`ifdef FRAME_PARSER_TIMEOUT_EN
    check("E_timeout_err_count", 32'(err_seen - err_base), 32'd1);
    check("E_timeout_errcnt", 32'(err_cnt), 32'h1);
    send_frame(12'h2C4, 12'h3B5, 0, 15, -1, 8'h00);
    idle(3);
    check("E_valid_count", 32'(valid_seen - valid_base), 32'd1);
    check("E_ch1", 32'(ch1_data), 32'h2C4);
    check("E_ch2", 32'(ch2_data), 32'h3B5);
`else
    check("E_no_timeout_err", 32'(err_seen - err_base), 32'd0);
    check("E_no_timeout_errcnt", 32'(err_cnt), 32'h0);
    send_frame(12'h123, 12'h456, 6, 15, -1, 8'h00);
    idle(3);
    check("E_valid_count", 32'(valid_seen - valid_base), 32'd1);
    check("E_ch1", 32'(ch1_data), 32'h123);
    check("E_ch2", 32'(ch2_data), 32'h456);
`endif

    // Reset pulse after byte 8, then good frame 123/456
    do_reset();
    send_frame(12'h777, 12'h666, 0, 8, -1, 8'h00);
    sys_rst = 1'b1;
    idle(1);
    check("F_ready_in_reset", 32'(rx_data_ready), 32'h0);
    sys_rst = 1'b0;
    send_frame(12'h123, 12'h456, 0, 15, -1, 8'h00);
    idle(3);
    check("F_err_count", 32'(err_seen - err_base), 32'd0);
    check("F_errcnt", 32'(err_cnt), 32'h0);
    check("F_valid_count", 32'(valid_seen - valid_base), 32'd1);
    check("F_ch1", 32'(ch1_data), 32'h123);
    check("F_ch2", 32'(ch2_data), 32'h456);

    check("valid_err_exclusive", 32'(both_seen), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_frame_parser.md
UART_FRAME_PARSER -- requirements
Module: uart_frame_parser

Interface
REQ-001 The block SHALL have parameter CLK_FRE, default 100, meaning sys_clk frequency in MHz.
REQ-002 The block SHALL have parameter TIMEOUT_US, default 200, meaning the maximum inter-byte gap in microseconds within a frame.
REQ-003 The block SHALL have port sys_clk, input, 1 bit: the single clock.
REQ-004 The block SHALL have port sys_rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port rx_data, input, 8 bits: received byte from the UART receiver.
REQ-006 The block SHALL have port rx_data_valid, input, 1 bit: rx_data is valid.
REQ-007 The block SHALL have port rx_data_ready, output, 1 bit: parser can accept a byte.
REQ-008 The block SHALL have ports ch1_data and ch2_data, output, 12 bits each: last good channel samples.
REQ-009 The block SHALL have port frame_valid, output, 1 bit: one-cycle pulse when a good frame completes.
REQ-010 The block SHALL have port frame_err, output, 1 bit: one-cycle pulse when an in-progress frame is aborted.
REQ-011 The block SHALL have port err_cnt, output, 16 bits: saturating count of aborted frames.

Function
REQ-012 A byte SHALL be accepted only in a cycle where rx_data_valid=1 and rx_data_ready=1; rx_data_ready SHALL be 1 whenever the block is out of reset.
REQ-013 Frame format, byte index 0..15: FF 00 00 FF, {0000,ch1[11:8]}, ch1[7:0], FF 00 00 00 00 FF, {0000,ch2[11:8]}, ch2[7:0], FF 00.
REQ-014 The FSM SHALL have states HUNT (matching indices 0-3) and PAYLOAD (indices 4-15), and SHALL hold a 4-bit byte index.
REQ-015 In HUNT, a byte mismatch SHALL restart matching: index becomes 1 if the byte is FF, otherwise 0; a HUNT mismatch SHALL NOT raise frame_err.
REQ-016 Accepting index 3 correctly SHALL move the FSM to PAYLOAD with index 4.
REQ-017 In PAYLOAD, each fixed byte (indices 6-11, 14, 15) SHALL match, and indices 4 and 12 SHALL have an upper nibble of 0; any violation SHALL pulse frame_err the next cycle, increment err_cnt, return the FSM to HUNT, and re-evaluate the byte as index 0.
REQ-018 Channel bytes SHALL be staged internally; ch1_data and ch2_data SHALL update together only on frame completion.
REQ-019 Accepting a correct index 15 SHALL, on the next cycle, update ch1_data and ch2_data, pulse frame_valid for 1 cycle, and return the FSM to HUNT with index 0.
REQ-020 ch1_data and ch2_data SHALL hold their values across aborted frames.
REQ-021 err_cnt SHALL saturate at FFFF.
REQ-022 frame_valid and frame_err SHALL never be asserted in the same cycle.

Reset
REQ-023 When sys_rst=1, the block SHALL set the state to HUNT and the index to 0; clear staging registers, ch1_data, ch2_data, frame_valid, frame_err, err_cnt and the timeout counter; and drive rx_data_ready to 0.
REQ-024 Reset asserted mid-frame SHALL discard the partial frame without a frame_err pulse or err_cnt increment.

Configuration
REQ-025 When FRAME_PARSER_TIMEOUT_EN is defined, the block SHALL abort a frame if more than CLK_FRE*TIMEOUT_US cycles pass between accepted bytes while in PAYLOAD or at HUNT index>0.
REQ-026 A timeout abort SHALL go to HUNT with index 0, pulse frame_err and increment err_cnt only if in PAYLOAD; the counter SHALL clear on every accepted byte.
REQ-027 When FRAME_PARSER_TIMEOUT_EN is undefined, the block SHALL have no timeout logic, and a partial frame SHALL wait indefinitely.

Structure
REQ-028 Shared package fpga_slave_pkg SHALL hold the frame length (16), the sync bytes, the fixed-byte table (index to expected value), and the FSM state typedef.
REQ-029 The timeout counter SHALL be a sub-module, uart_byte_timer, with inputs clear and enable and output expired; it SHALL be instantiated only under FRAME_PARSER_TIMEOUT_EN.

Verification
REQ-030 Good frame, ch1=0x5A3, ch2=0x0F1 -> one frame_valid pulse; ch1_data=0x5A3; ch2_data=0x0F1; err_cnt=0.
REQ-031 Garbage 12 34 FF, then FF 00 00 FF and the rest of a frame with ch1=0x001, ch2=0xFFF -> frame_valid; ch1_data=0x001; ch2_data=0xFFF; no frame_err.
REQ-032 Good frame (0x5A3/0x0F1), then a frame with byte 4=0x15 -> frame_err once; err_cnt=1; outputs remain 0x5A3/0x0F1.
REQ-033 Frame with byte 9=0x01, immediately followed by a good frame (0x7FF/0x800) -> frame_err, err_cnt=1, then frame_valid with 0x7FF/0x800.
REQ-034 With FRAME_PARSER_TIMEOUT_EN, TIMEOUT_US=2, CLK_FRE=100: send 6 bytes then idle 250 cycles -> frame_err and err_cnt=1; a following good frame decodes.
REQ-035 Reset pulse after byte 8 of a frame, then a good frame 0x123/0x456 -> no frame_err; err_cnt=0; frame_valid with 0x123/0x456.
